fazyrv_dbus_if: RTL and testbench

- Data-bus master between the core's sequencer and external data memory.
- Sits directly upstream of the data scratchpad: it returns load words to the scratchpad's parallel-load input and drives store words taken from the scratchpad's parallel output.
- Performs one single-beat strobe/ack transaction per load or store, with byte enables, word-aligned address, optional timeout and a one-cycle completion pulse.

---
 rtl/fazyrv_pkg.sv | 29 ++
 rtl/fazyrv_tmo_cnt.sv | 30 +++
 rtl/fazyrv_dbus_if.sv | 171 +++++++++++++++++
 tb/tb_fazyrv_dbus_if.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fazyrv_pkg.sv
// rtl/fazyrv_pkg.sv - shared data-bus types and byte-enable helper
package fazyrv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } dbus_state_t;

    // Byte enables for a b/h/w access; the lane offset comes from the low address bits.
    function automatic logic [3:0] dbus_be(
        input logic       ls_b,
        input logic       ls_h,
        input logic       ls_w,
        input logic [1:0] adr_lo
    );
        logic [3:0] be;
        be = 4'b0000;
        if (ls_b) begin
            be = 4'b0001 << adr_lo;
        end else if (ls_h) begin
            be = 4'b0011 << {adr_lo[1], 1'b0};
        end else if (ls_w) begin
            be = 4'b1111;
        end
        return be;
    endfunction

endpackage

// File: rtl/fazyrv_tmo_cnt.sv
// rtl/fazyrv_tmo_cnt.sv - ack timeout counter for the data bus
module fazyrv_tmo_cnt #(
    parameter int TMO_CYC = 4
) (
    input  logic clk_i,
    input  logic rst_in,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int            W    = $clog2(TMO_CYC + 1);
    localparam logic [W-1:0] LAST = W'(TMO_CYC - 1);

    logic [W-1:0] cnt;

    // Held at zero outside the bus phase, counts every strobe cycle that goes unacknowledged.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (inc_i) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired_o = (cnt == LAST);

endmodule

// File: rtl/fazyrv_dbus_if.sv
// rtl/fazyrv_dbus_if.sv - single-beat strobe/ack data-bus master for loads and stores
module fazyrv_dbus_if
    import fazyrv_pkg::*;
#(
    parameter int TMO_CYC = 0,
    parameter     CONF    = "MIN"
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        start_i,
    input  logic        instr_ld_i,
    input  logic        instr_st_i,
    input  logic        ls_b_i,
    input  logic        ls_h_i,
    input  logic        ls_w_i,
    input  logic        misalngd_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] st_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ld_par_o,
    output logic [31:0] ld_data_o,
    output logic        err_o,
    output logic        dmem_stb_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_adr_o,
    output logic [31:0] dmem_dat_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_dat_i
);

    // The minimal core has no trap path, so a timeout is never reported there.
    localparam bit ERR_EN = (CONF != "MIN");

    dbus_state_t state, state_nxt;

    logic [29:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic        ld_q;
    logic        mis_q;
    logic        err_q;
    logic [31:0] ld_data_q;
    logic        tmo;
    logic        req_ok;
    logic        req_mis;

    assign req_mis = start_i & misalngd_i;
    assign req_ok  = start_i & (instr_ld_i | instr_st_i) & ~misalngd_i;

    generate
        if (TMO_CYC > 0) begin : g_tmo
            fazyrv_tmo_cnt #(
                .TMO_CYC (TMO_CYC)
            ) u_tmo_cnt (
                .clk_i     (clk_i),
                .rst_in    (rst_in),
                .clr_i     (state != ST_BUS),
                .inc_i     ((state == ST_BUS) & ~dmem_ack_i),
                .expired_o (tmo)
            );
        end else begin : g_no_tmo
            assign tmo = 1'b0;
        end
    endgenerate

    // State register; async reset so the strobe decoded from it drops immediately.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: misaligned requests skip the bus, ack beats a coincident timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_mis) begin
                    state_nxt = ST_DONE;
                end else if (req_ok) begin
                    state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                if (dmem_ack_i || tmo) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; bus data and enables are gated to zero outside the bus phase.
    always_comb begin
        busy_o     = 1'b0;
        done_o     = 1'b0;
        ld_par_o   = 1'b0;
        err_o      = 1'b0;
        dmem_stb_o = 1'b0;
        dmem_we_o  = 1'b0;
        dmem_be_o  = 4'b0000;
        dmem_dat_o = 32'h0;
        case (state)
            ST_BUS: begin
                busy_o     = 1'b1;
                dmem_stb_o = 1'b1;
                dmem_we_o  = we_q;
                dmem_be_o  = be_q;
                dmem_dat_o = dat_q;
            end
            ST_DONE: begin
                done_o   = 1'b1;
                ld_par_o = ld_q & ~err_q & ~mis_q;
                err_o    = ERR_EN & err_q;
            end
            default: ;
        endcase
    end

    // Request capture in IDLE, read-data capture on ack, timeout flag on expiry.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            adr_q     <= '0;
            dat_q     <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            ld_q      <= 1'b0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
            ld_data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_mis) begin
                        ld_q  <= instr_ld_i;
                        mis_q <= 1'b1;
                        err_q <= 1'b0;
                    end else if (req_ok) begin
                        adr_q <= adr_i[31:2];
                        dat_q <= st_data_i;
                        be_q  <= dbus_be(ls_b_i, ls_h_i, ls_w_i, adr_i[1:0]);
                        we_q  <= instr_st_i;
                        ld_q  <= instr_ld_i & ~instr_st_i;
                        mis_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                end
                ST_BUS: begin
                    if (dmem_ack_i) begin
                        if (!we_q) begin
                            ld_data_q <= dmem_dat_i;
                        end
                    end else if (tmo) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ld_data_o  = ld_data_q;
    assign dmem_adr_o = {adr_q, 2'b00};

endmodule

// File: tb/tb_fazyrv_dbus_if.sv
// tb/tb_fazyrv_dbus_if.sv - self-checking bench for fazyrv_dbus_if
module tb_fazyrv_dbus_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, ld, st, ls_b, ls_h, ls_w, mis;
    logic [31:0] adr, st_data;
    logic        busy, done, ld_par, err, stb, we, ack;
    logic [31:0] ld_data, m_adr, m_dat_o, m_dat_i;
    logic [3:0]  be;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic        ld, st, b, h, w, mis;
        logic [31:0] adr, st_data;
        int          waits;
        logic [31:0] rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_adr;
        logic        exp_we;
        int          exp_stb;
        int          exp_lat;
        logic        exp_ld_par, exp_err;
        logic [31:0] exp_ld_data;
    } vec_t;

    vec_t vecs[8];
    vec_t sb[$];

    fazyrv_dbus_if #(.TMO_CYC(4), .CONF("INT")) dut (
        .clk_i(clk), .rst_in(rst_n), .start_i(start),
        .instr_ld_i(ld), .instr_st_i(st), .ls_b_i(ls_b), .ls_h_i(ls_h), .ls_w_i(ls_w),
        .misalngd_i(mis), .adr_i(adr), .st_data_i(st_data),
        .busy_o(busy), .done_o(done), .ld_par_o(ld_par), .ld_data_o(ld_data), .err_o(err),
        .dmem_stb_o(stb), .dmem_we_o(we), .dmem_be_o(be), .dmem_adr_o(m_adr),
        .dmem_dat_o(m_dat_o), .dmem_ack_i(ack), .dmem_dat_i(m_dat_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_req();
        start = 0; ld = 0; st = 0; ls_b = 0; ls_h = 0; ls_w = 0; mis = 0;
    endtask

    task automatic run(input vec_t v);
        int   cyc;
        int   stb_n;
        bit   seen;
        vec_t e;
        ld = v.ld; st = v.st; ls_b = v.b; ls_h = v.h; ls_w = v.w; mis = v.mis;
        adr = v.adr; st_data = v.st_data; start = 1;
        sb.push_back(v);
        step();
        clear_req();
        cyc = 1; stb_n = 0; seen = 0;
        while (cyc < 30 && !seen) begin
            ack = 0;
            if (stb) begin
                stb_n++;
                if (stb_n == 1) begin
                    chk({v.name, " be"}, {28'h0, be}, {28'h0, v.exp_be});
                    chk({v.name, " adr"}, m_adr, v.exp_adr);
                    chk({v.name, " we"}, {31'h0, we}, {31'h0, v.exp_we});
                    if (v.st) chk({v.name, " dat_o"}, m_dat_o, v.st_data);
                end
                if (stb_n == v.waits + 1) begin
                    ack = 1;
                    m_dat_i = v.rd;
                end
            end
            if (done) begin
                seen = 1;
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL %s scoreboard: done with no pending request", v.name);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, " latency"}, cyc, e.exp_lat);
                    chk({e.name, " stb cycles"}, stb_n, e.exp_stb);
                    chk({e.name, " ld_par"}, {31'h0, ld_par}, {31'h0, e.exp_ld_par});
                    chk({e.name, " err"}, {31'h0, err}, {31'h0, e.exp_err});
                    chk({e.name, " ld_data"}, ld_data, e.exp_ld_data);
                end
            end else begin
                step();
                cyc++;
            end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL %s done timeout: got no done expected done", v.name);
        end
        ack = 0;
        step();
        chk({v.name, " done width"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        //        name        ld st b  h  w  mis adr       st_data       waits rd            be      adr_o      we stb lat par err ld_data
        vecs[0] = '{"wld",     1, 0, 0, 0, 1, 0, 32'h100, 32'h0,        2,  32'hDEADBEEF, 4'b1111, 32'h100, 0, 3, 4, 1, 0, 32'hDEADBEEF};
        vecs[1] = '{"bst",     0, 1, 1, 0, 0, 0, 32'h203, 32'hAB000000, 0,  32'h0,        4'b1000, 32'h200, 1, 1, 2, 0, 0, 32'hDEADBEEF};
        vecs[2] = '{"hld2",    1, 0, 0, 1, 0, 0, 32'h2,   32'h0,        1,  32'h12345678, 4'b1100, 32'h0,   0, 2, 3, 1, 0, 32'h12345678};
        vecs[3] = '{"hld0",    1, 0, 0, 1, 0, 0, 32'h0,   32'h0,        0,  32'hCAFEF00D, 4'b0011, 32'h0,   0, 1, 2, 1, 0, 32'hCAFEF00D};
        vecs[4] = '{"mis",     1, 0, 0, 0, 1, 1, 32'h1,   32'h0,        0,  32'h0,        4'b0000, 32'h0,   0, 0, 1, 0, 0, 32'hCAFEF00D};
        vecs[5] = '{"tmo",     1, 0, 0, 0, 1, 0, 32'h40,  32'h0,        99, 32'h0,        4'b1111, 32'h40,  0, 4, 5, 0, 1, 32'hCAFEF00D};
        vecs[6] = '{"ack_tmo", 1, 0, 0, 0, 1, 0, 32'h44,  32'h0,        3,  32'h0BADC0DE, 4'b1111, 32'h44,  0, 4, 5, 1, 0, 32'h0BADC0DE};
        vecs[7] = '{"bst1",    0, 1, 1, 0, 0, 0, 32'h11,  32'h00005500, 1,  32'h0,        4'b0010, 32'h10,  1, 2, 3, 0, 0, 32'h0BADC0DE};

        rst_n = 0; clear_req(); adr = 0; st_data = 0; ack = 0; m_dat_i = 0;
        step(); step();
        chk("rst stb", {31'h0, stb}, 32'h0);
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst done", {31'h0, done}, 32'h0);
        chk("rst be", {28'h0, be}, 32'h0);
        chk("rst we", {31'h0, we}, 32'h0);
        chk("rst ld_data", ld_data, 32'h0);
        chk("rst adr_o", m_adr, 32'h0);
        rst_n = 1;
        step();

        for (int i = 0; i < 8; i++) run(vecs[i]);

        // start without load/store is ignored, as is an ack while idle
        start = 1;
        step();
        start = 0;
        chk("bare start stb", {31'h0, stb}, 32'h0);
        chk("bare start done", {31'h0, done}, 32'h0);
        ack = 1;
        step();
        chk("idle ack done", {31'h0, done}, 32'h0);
        ack = 0;

        // second start while busy and start during DONE are both ignored
        ld = 1; ls_w = 1; adr = 32'h500; start = 1;
        step();
        clear_req();
        chk("busy stb", {31'h0, stb}, 32'h1);
        st = 1; ls_b = 1; adr = 32'h600; start = 1;
        step();
        clear_req();
        chk("busy adr held", m_adr, 32'h500);
        chk("busy we held", {31'h0, we}, 32'h0);
        ack = 1; m_dat_i = 32'h11223344;
        step();
        ack = 0;
        chk("busy done", {31'h0, done}, 32'h1);
        chk("busy ld_par", {31'h0, ld_par}, 32'h1);
        st = 1; ls_w = 1; adr = 32'h700; start = 1;
        step();
        clear_req();
        chk("done start stb", {31'h0, stb}, 32'h0);
        step();
        chk("done start stb2", {31'h0, stb}, 32'h0);
        chk("busy ld_data", ld_data, 32'h11223344);

        // reset during BUS drops the strobe without a clock edge
        ld = 1; ls_w = 1; adr = 32'h300; start = 1;
        step();
        clear_req();
        chk("pre-rst stb", {31'h0, stb}, 32'h1);
        #1 rst_n = 0;
        #1;
        chk("async rst stb", {31'h0, stb}, 32'h0);
        chk("async rst busy", {31'h0, busy}, 32'h0);
        chk("async rst be", {28'h0, be}, 32'h0);
        step();
        rst_n = 1;
        step();
        chk("post-rst stb", {31'h0, stb}, 32'h0);
        run(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
